// File: rtl/lopd_pkg.sv
// Shared constants and elaboration helpers for the pipelined leading-one
// detector / normaliser.
package lopd_pkg;

  localparam int DEF_SIZE_DATA  = 24;
  localparam int DEF_SIZE_CHUNK = 8;

  // Number of first-stage sub-detectors for a given data/chunk split.
  function automatic int f_num_chunks(input int data, input int chunk);
    return data / chunk;
  endfunction

  // Leading-zero count width; must be able to hold the value 'data' itself.
  function automatic int f_lzc_width(input int data);
    return $clog2(data + 1);
  endfunction

  function automatic bit f_is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/lopd_chunk.sv
// Combinational sub-detector: position of the highest set bit within one chunk.
// The local position reads 0 when the chunk is all zeros.
module lopd_chunk #(
  parameter int SIZE_CHUNK = 8,
  parameter int SIZE_POS   = $clog2(SIZE_CHUNK)
) (
  input  logic [SIZE_CHUNK-1:0] i_chunk,
  output logic [SIZE_POS-1:0]   o_pos,
  output logic                  o_zero
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    o_pos  = '0;
    o_zero = 1'b1;
    for (int i = 0; i < SIZE_CHUNK; i++) begin
      if (i_chunk[i]) begin
        o_pos  = SIZE_POS'(i);
        o_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lopd_norm_pipe.sv
// Two-stage leading-one position detector and left normaliser with a
// valid/ready handshake. Stage 1 runs per-chunk detectors; stage 2 picks the
// highest non-zero chunk and produces position, leading-zero count and the
// normalised word. Both stages hold under backpressure.
module lopd_norm_pipe
  import lopd_pkg::*;
#(
  parameter int SIZE_DATA  = DEF_SIZE_DATA,
  parameter int SIZE_CHUNK = DEF_SIZE_CHUNK,
  parameter int SIZE_LOPD  = $clog2(SIZE_DATA),
  parameter int SIZE_LZC   = f_lzc_width(SIZE_DATA),
  parameter int SIZE_TAG   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic [SIZE_TAG-1:0]  i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_LOPD-1:0] o_one_position,
  output logic [SIZE_LZC-1:0]  o_lz_count,
  output logic [SIZE_DATA-1:0] o_norm_data,
  output logic                 o_zero_flag,
  output logic [SIZE_TAG-1:0]  o_tag
);

  localparam int NUM_CHUNKS = f_num_chunks(SIZE_DATA, SIZE_CHUNK);
  localparam int CPOS_W     = $clog2(SIZE_CHUNK);

  if (SIZE_DATA % SIZE_CHUNK != 0) begin : g_chk_div
    $error("lopd_norm_pipe: SIZE_DATA must be a multiple of SIZE_CHUNK");
  end
  if (!f_is_pow2(SIZE_CHUNK) || SIZE_CHUNK < 2) begin : g_chk_pow2
    $error("lopd_norm_pipe: SIZE_CHUNK must be a power of two >= 2");
  end
  if (SIZE_LZC < f_lzc_width(SIZE_DATA)) begin : g_chk_lzc
    $error("lopd_norm_pipe: SIZE_LZC too narrow to hold SIZE_DATA");
  end

  // Stage-1 combinational detector outputs
  logic [NUM_CHUNKS-1:0] czero_d;
  logic [CPOS_W-1:0]     cpos_d [NUM_CHUNKS];

  // Stage-1 registers
  logic                  v1_q;
  logic [SIZE_DATA-1:0]  data1_q;
  logic [SIZE_TAG-1:0]   tag1_q;
  logic [NUM_CHUNKS-1:0] czero1_q;
  logic [CPOS_W-1:0]     cpos1_q [NUM_CHUNKS];

  // Stage-2 next-state and registers
  logic [SIZE_LOPD-1:0]  pos_d;
  logic [SIZE_LZC-1:0]   lz_d;
  logic [SIZE_DATA-1:0]  norm_d;
  logic                  zero_d;
  int                    pos_int;

  logic                  valid_q;
  logic [SIZE_LOPD-1:0]  pos_q;
  logic [SIZE_LZC-1:0]   lz_q;
  logic [SIZE_DATA-1:0]  norm_q;
  logic                  zero_q;
  logic [SIZE_TAG-1:0]   tag_q;

  logic adv1;
  logic adv2;

  // A stage advances when it is empty or the stage after it is moving.
  assign adv2    = ~valid_q | i_ready;
  assign adv1    = ~v1_q | adv2;
  assign o_ready = adv1;

  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_chunk
    lopd_chunk #(
      .SIZE_CHUNK (SIZE_CHUNK),
      .SIZE_POS   (CPOS_W)
    ) u_chunk (
      .i_chunk (i_data[g*SIZE_CHUNK +: SIZE_CHUNK]),
      .o_pos   (cpos_d[g]),
      .o_zero  (czero_d[g])
    );
  end

  // Stage 1: capture the word, tag and per-chunk detector results.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q     <= 1'b0;
      data1_q  <= '0;
      tag1_q   <= '0;
      czero1_q <= '0;
      for (int k = 0; k < NUM_CHUNKS; k++) cpos1_q[k] <= '0;
    end else if (adv1) begin
      v1_q     <= i_valid;
      data1_q  <= i_data;
      tag1_q   <= i_tag;
      czero1_q <= czero_d;
      for (int k = 0; k < NUM_CHUNKS; k++) cpos1_q[k] <= cpos_d[k];
    end
  end

  // Stage 2 combine: the highest non-zero chunk owns the leading one.
  always_comb begin
    pos_int = 0;
    zero_d  = &czero1_q;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (!czero1_q[k]) pos_int = k * SIZE_CHUNK + int'(cpos1_q[k]);
    end
    if (zero_d) begin
      pos_d  = '0;
      lz_d   = SIZE_LZC'(SIZE_DATA);
      norm_d = '0;
    end else begin
      pos_d  = SIZE_LOPD'(pos_int);
      lz_d   = SIZE_LZC'(SIZE_DATA - 1 - pos_int);
      norm_d = data1_q << lz_d;
    end
  end

  // Stage 2: output registers, held while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      pos_q   <= '0;
      lz_q    <= '0;
      norm_q  <= '0;
      zero_q  <= 1'b0;
      tag_q   <= '0;
    end else if (adv2) begin
      valid_q <= v1_q;
      pos_q   <= pos_d;
      lz_q    <= lz_d;
      norm_q  <= norm_d;
      zero_q  <= zero_d;
      tag_q   <= tag1_q;
    end
  end

  assign o_valid        = valid_q;
  assign o_one_position = pos_q;
  assign o_lz_count     = lz_q;
  assign o_norm_data    = norm_q;
  assign o_zero_flag    = zero_q;
  assign o_tag          = tag_q;

endmodule

// File: tb/tb_lopd_norm_pipe.sv
// Directed and random checks of lopd_norm_pipe at 24/8 and 32/8 geometries,
// using a scoreboard of expected beats built from a bit-scan reference model.
module tb_lopd_norm_pipe;

  typedef struct packed {
    logic [5:0]  pos;
    logic [5:0]  lz;
    logic [31:0] norm;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;

  logic clk;
  logic rst;

  logic        a_valid, a_ready, a_iready, a_ovalid, a_zero;
  logic [23:0] a_data, a_norm;
  logic [3:0]  a_tag, a_otag;
  logic [4:0]  a_pos, a_lz;

  logic        b_valid, b_ready, b_iready, b_ovalid, b_zero;
  logic [31:0] b_data, b_norm;
  logic [3:0]  b_tag, b_otag;
  logic [4:0]  b_pos;
  logic [5:0]  b_lz;

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  bit   acc_a, acc_b;

  lopd_norm_pipe u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready),
    .i_data(a_data), .i_tag(a_tag), .o_valid(a_ovalid), .i_ready(a_iready),
    .o_one_position(a_pos), .o_lz_count(a_lz), .o_norm_data(a_norm),
    .o_zero_flag(a_zero), .o_tag(a_otag)
  );

  lopd_norm_pipe #(.SIZE_DATA(32), .SIZE_CHUNK(8)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready),
    .i_data(b_data), .i_tag(b_tag), .o_valid(b_ovalid), .i_ready(b_iready),
    .o_one_position(b_pos), .o_lz_count(b_lz), .o_norm_data(b_norm),
    .o_zero_flag(b_zero), .o_tag(b_otag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] d, input int w, input logic [3:0] t);
    exp_t e;
    int   p;
    logic [63:0] wide;
    logic [63:0] mask;
    p = -1;
    for (int i = 0; i < w; i++) if (d[i]) p = i;
    e.tag = t;
    if (p < 0) begin
      e.zero = 1'b1;
      e.pos  = '0;
      e.lz   = 6'(w);
      e.norm = '0;
    end else begin
      e.zero = 1'b0;
      e.pos  = 6'(p);
      e.lz   = 6'(w - 1 - p);
      mask   = (64'd1 << w) - 64'd1;
      wide   = (64'(d) << (w - 1 - p)) & mask;
      e.norm = wide[31:0];
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: score outputs and accepts just before the edge, then advance.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    acc_a = 1'b0;
    acc_b = 1'b0;
    if (!rst && a_ovalid === 1'b1 && a_iready) begin
      chk("a_expected_beat", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_pos",  32'(a_pos),  32'(e.pos));
        chk("a_lz",   32'(a_lz),   32'(e.lz));
        chk("a_norm", 32'(a_norm), e.norm);
        chk("a_zero", 32'(a_zero), 32'(e.zero));
        chk("a_tag",  32'(a_otag), 32'(e.tag));
      end
    end
    if (!rst && b_ovalid === 1'b1 && b_iready) begin
      chk("b_expected_beat", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_pos",  32'(b_pos),  32'(e.pos));
        chk("b_lz",   32'(b_lz),   32'(e.lz));
        chk("b_norm", b_norm,      e.norm);
        chk("b_zero", 32'(b_zero), 32'(e.zero));
        chk("b_tag",  32'(b_otag), 32'(e.tag));
      end
    end
    if (!rst && a_valid && a_ready === 1'b1) begin
      acc_a = 1'b1;
      qa.push_back(model({8'h00, a_data}, 24, a_tag));
    end
    if (!rst && b_valid && b_ready === 1'b1) begin
      acc_b = 1'b1;
      qb.push_back(model(b_data, 32, b_tag));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);
  endtask

  logic [23:0] bp_data [4];
  logic [23:0] snap_norm;
  logic [3:0]  snap_tag;
  logic [4:0]  snap_pos;
  int          idx;
  int          budget;
  int          accepted;

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0; a_tag = '0; a_iready = 1'b1;
    b_valid = 1'b0; b_data = '0; b_tag = '0; b_iready = 1'b1;
    bp_data[0] = 24'h000100; bp_data[1] = 24'h400000;
    bp_data[2] = 24'h0000F0; bp_data[3] = 24'h000003;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(a_ovalid), 32'd0);
    chk("rst_pos",   32'(a_pos),    32'd0);
    chk("rst_lz",    32'(a_lz),     32'd0);
    chk("rst_norm",  32'(a_norm),   32'd0);
    chk("rst_zero",  32'(a_zero),   32'd0);
    chk("rst_tag",   32'(a_otag),   32'd0);
    chk("rst_ready", 32'(a_ready),  32'd1);
    chk("rst_b_valid", 32'(b_ovalid), 32'd0);

    // Single beat, two-cycle latency.
    a_valid = 1'b1; a_data = 24'h000001; a_tag = 4'd1;
    tick();
    a_valid = 1'b0;
    chk("lat_cycle1_valid", 32'(a_ovalid), 32'd0);
    tick();
    chk("lat_cycle2_valid", 32'(a_ovalid), 32'd1);
    drain();

    // Back-to-back beats.
    a_valid = 1'b1; a_data = 24'h800000; a_tag = 4'd2;
    tick();
    a_data = 24'h00A000; a_tag = 4'd3;
    tick();
    a_valid = 1'b0;
    tick();
    chk("b2b_second_valid", 32'(a_ovalid), 32'd1);
    chk("b2b_second_tag",   32'(a_otag),   32'd3);
    drain();

    // All-zero word.
    a_valid = 1'b1; a_data = 24'h000000; a_tag = 4'd4;
    tick();
    a_valid = 1'b0;
    drain();

    // Backpressure: two beats fill the pipe, then a three-cycle stall.
    a_iready = 1'b0;
    a_valid = 1'b1; a_data = bp_data[0]; a_tag = 4'd1;
    tick();
    a_data = bp_data[1]; a_tag = 4'd2;
    tick();
    chk("bp_valid_held", 32'(a_ovalid), 32'd1);
    chk("bp_ready_low",  32'(a_ready),  32'd0);
    snap_norm = a_norm; snap_tag = a_otag; snap_pos = a_pos;
    chk("bp_head_tag", 32'(snap_tag), 32'd1);
    a_data = bp_data[2]; a_tag = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(a_ovalid), 32'd1);
      chk("stall_ready", 32'(a_ready),  32'd0);
      chk("stall_tag",   32'(a_otag),   32'(snap_tag));
      chk("stall_norm",  32'(a_norm),   32'(snap_norm));
      chk("stall_pos",   32'(a_pos),    32'(snap_pos));
    end
    a_iready = 1'b1;
    idx = 2;
    budget = 0;
    while (idx < 4 && budget < 20) begin
      a_valid = 1'b1; a_data = bp_data[idx]; a_tag = 4'(idx + 1);
      tick();
      if (acc_a) idx++;
      budget++;
    end
    a_valid = 1'b0;
    chk("bp_all_accepted", 32'(idx), 32'd4);
    drain();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_duplicate", 32'(a_ovalid), 32'd0);
    end

    // Reset with both stages full; beats offered during reset are ignored.
    a_iready = 1'b0;
    a_valid = 1'b1; a_data = 24'h001000; a_tag = 4'd5;
    tick();
    a_data = 24'h020000; a_tag = 4'd6;
    tick();
    chk("prerst_ready", 32'(a_ready), 32'd0);
    a_data = 24'h000400; a_tag = 4'd7;
    rst = 1'b1;
    tick();
    qa.delete();
    qb.delete();
    rst = 1'b0;
    a_valid = 1'b0;
    chk("midrst_valid", 32'(a_ovalid), 32'd0);
    chk("midrst_tag",   32'(a_otag),   32'd0);
    chk("midrst_norm",  32'(a_norm),   32'd0);
    chk("midrst_pos",   32'(a_pos),    32'd0);
    chk("midrst_ready", 32'(a_ready),  32'd1);
    a_iready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("held_beat_gone", 32'(a_ovalid), 32'd0);
    end

    // 32-bit geometry: directed word, then random sweep with random stalls.
    b_valid = 1'b1; b_data = 32'h00010000; b_tag = 4'd9;
    tick();
    b_valid = 1'b0;
    tick();
    chk("b32_valid", 32'(b_ovalid), 32'd1);
    chk("b32_pos",   32'(b_pos),    32'd16);
    chk("b32_lz",    32'(b_lz),     32'd15);
    chk("b32_norm",  b_norm,        32'h80000000);
    drain();

    accepted = 0;
    budget = 0;
    while (accepted < 10000 && budget < 40000) begin
      b_valid  = ($urandom_range(0, 3) != 0);
      b_data   = $urandom >> $urandom_range(0, 32);
      b_tag    = 4'($urandom);
      b_iready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc_b) accepted++;
      budget++;
    end
    b_valid = 1'b0;
    b_iready = 1'b1;
    chk("sweep_count", 32'(accepted), 32'd10000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lopd_norm_pipe.md
Name: lopd_norm_pipe

Overview:
Parametrised, pipelined leading-one position detector and normaliser for the floating-point datapath. It generalises the fixed 24-bit combinational LOPD to any width that splits evenly into equal chunks. It adds a leading-zero count, a left-normalised mantissa output, a tag sideband and a valid/ready handshake with full backpressure. It sits between the adder/subtractor result and the exponent-adjust stage.

Parameters:
SIZE_DATA, 24, input data width; must be a multiple of SIZE_CHUNK
SIZE_CHUNK, 8, width of each first-stage sub-detector; power of two, ≥2
SIZE_LOPD, $clog2(SIZE_DATA), width of position output
SIZE_LZC, $clog2(SIZE_DATA+1), width of leading-zero count; must hold the value SIZE_DATA
SIZE_TAG, 4, sideband tag width

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  input beat valid
o_ready  output  1  block can accept input this cycle
i_data  input  SIZE_DATA  word to scan
i_tag  input  SIZE_TAG  sideband carried unchanged with the beat
o_valid  output  1  output beat valid
i_ready  input  1  downstream accepts output
o_one_position  output  SIZE_LOPD  bit index of most-significant 1 (LSB = 0)
o_lz_count  output  SIZE_LZC  leading zeros from MSB
o_norm_data  output  SIZE_DATA  i_data << o_lz_count
o_zero_flag  output  1  i_data was all zeros
o_tag  output  SIZE_TAG  tag of the output beat

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst. All registers clear on the i_clk edge where i_rst=1.
- Reset values: o_valid=0, o_one_position=0, o_lz_count=0, o_norm_data=0, o_zero_flag=0, o_tag=0. Internal stage-1 valid=0.
- Two register stages. Latency is 2 cycles from input accept to o_valid=1 when there is no stall. Throughput is one beat per cycle.
- Input accept: i_valid & o_ready. Output transfer: o_valid & i_ready.
- Stage-2 advance: adv2 = ~o_valid | i_ready. Stage-1 advance: adv1 = ~v1 | adv2.
- o_ready = adv1. This is a combinational path from i_ready and is permitted.
- Stage 1 (NUM_CHUNKS = SIZE_DATA/SIZE_CHUNK), registered on adv1:
  - data and tag.
  - Per-chunk zero flag.
  - Per-chunk local position of the highest 1. The local position is 0 when the chunk is zero.
  - v1 <= i_valid.
- Stage 2, registered on adv2:
  - Select the highest-index non-zero chunk k.
  - pos = k*SIZE_CHUNK + local_k.
  - lz = SIZE_DATA-1-pos.
  - norm = data << lz.
  - zero_flag = AND of all chunk zero flags.
  - o_valid <= v1.
- All-zero input: o_zero_flag=1, o_one_position=0, o_lz_count=SIZE_DATA, o_norm_data=0.
- Stall: while o_valid=1 and i_ready=0, all outputs hold stable. Stage 1 still fills if it is empty. With both stages full, o_ready=0.
- Simultaneous transfer and accept with both stages full and i_ready=1: both stages shift in the same cycle, with no bubble.
- Stage registers load only on their advance; payload is not cleared when valid drops.
- Beats leave strictly in order. Tags are never reordered or dropped.
- i_rst mid-operation: in-flight beats are discarded. o_valid=0 on the next cycle and o_ready=1 one cycle after i_rst deasserts.
- Any i_valid asserted while i_rst=1 is ignored.
- o_norm_data MSB is 1 whenever o_zero_flag=0.

Decomposition:
- Package lopd_pkg:
  - Default SIZE_DATA/SIZE_CHUNK constants.
  - Function f_num_chunks(data, chunk).
  - Function f_lzc_width(data).
  - Elaboration-time checks: divisibility and power-of-two chunk.
- Sub-module lopd_chunk:
  - Combinational; parameter SIZE_CHUNK.
  - Outputs local position and zero flag.
  - Instantiated NUM_CHUNKS times in stage 1 via generate.

Test Plan:
- Defaults, i_ready=1, i_data=0x000001, tag 1 → 2 cycles later: pos 0, lz 23, norm 0x800000, zero 0, tag 1.
- i_data=0x800000, then 0x00A000 back-to-back → pos 23/lz 0/norm 0x800000, then pos 15/lz 8/norm 0xA00000 on consecutive cycles.
- i_data=0x000000 → zero_flag 1, pos 0, lz 24, norm 0.
- Backpressure: 4 beats with tags 1..4 streamed, i_ready=0 for 3 cycles from first o_valid:
  - o_ready drops once 2 beats are held.
  - Outputs stay stable while stalled.
  - After release, tags emerge 1,2,3,4 with no loss or duplication.
- Reset mid-stream: i_rst=1 for 1 cycle with both stages full → next cycle o_valid=0, outputs 0; held beats never appear.
- SIZE_DATA=32, SIZE_CHUNK=8, i_data=0x00010000 → pos 16, lz 15, norm 0x80000000; random sweep of 10k words checked against a reference model.
